// File: rtl/i2c_master_nb.sv
// i2c_master_nb: frame-based I2C master, SCL push-pull, SDA open-drain.
// Read frames (rd_data port) exist only when I2C_READ_EN is defined.
module i2c_master_nb #(
    parameter int DATA_BYTES = 3,
    parameter int QDIV       = 1
) (
    input  logic                    clock_i2c,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [3:0]              nbytes,
    input  logic [8*DATA_BYTES-1:0] i2c_data,
    output logic                    busy,
    output logic                    tr_end,
    output logic                    ack,
    output logic                    i2c_sclk,
`ifdef I2C_READ_EN
    output logic [8*DATA_BYTES-1:0] rd_data,
`endif
    inout  wire                     i2c_sdat
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = $clog2(DATA_BYTES + 1);
    localparam int QW  = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        IDLE, START, BYTE, ACKB, STOP, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [QW-1:0]  qcnt_q, qcnt_d;
    logic [1:0]     ph_q, ph_d;
    logic [2:0]     bit_q, bit_d;
    logic [BCW-1:0] byte_q, byte_d;
    logic [BCW-1:0] nb_q, nb_d;
    logic [BCW-1:0] nb_clamp;
    logic [DW-1:0]  sh_q, sh_d;
    logic           ack_q, ack_d;
    logic           tick, rx, sda_in, sda_low;
    logic           rd_mode_q;

`ifdef I2C_READ_EN
    logic           rd_mode_d;
    logic [DW-1:0]  rd_q, rd_d;
    assign rd_data = rd_q;
`else
    assign rd_mode_q = 1'b0;
`endif

    assign sda_in   = i2c_sdat;
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
    assign tick     = (qcnt_q == QW'(QDIV - 1));
    assign rx       = rd_mode_q && (byte_q != BCW'(1));
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign tr_end   = (state_q == DONE);
    assign ack      = ack_q;

    // Clamp the requested byte count into 1..DATA_BYTES.
    always_comb begin
        nb_clamp = nbytes[BCW-1:0];
        if (nbytes == 4'd0) begin
            nb_clamp = BCW'(1);
        end else if (int'(nbytes) > DATA_BYTES) begin
            nb_clamp = BCW'(DATA_BYTES);
        end
    end

    // Next-state: quarter timing, bit/byte sequencing, ACK capture.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        nb_d    = nb_q;
        sh_d    = sh_q;
        ack_d   = ack_q;
`ifdef I2C_READ_EN
        rd_mode_d = rd_mode_q;
        rd_d      = rd_q;
`endif
        if (busy) begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
            if (tick) ph_d = ph_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    sh_d    = i2c_data;
                    nb_d    = nb_clamp;
                    ack_d   = 1'b0;
                    qcnt_d  = '0;
                    ph_d    = '0;
                    bit_d   = '0;
                    byte_d  = BCW'(1);
`ifdef I2C_READ_EN
                    rd_mode_d = i2c_data[DW-8];
                    rd_d      = '0;
`endif
                end
            end
            START: begin
                if (tick && ph_q == 2'd1) begin
                    state_d = BYTE;
                    ph_d    = '0;
                end
            end
            BYTE: begin
`ifdef I2C_READ_EN
                if (tick && ph_q == 2'd2 && rx) rd_d = {rd_q[DW-2:0], sda_in};
`endif
                if (tick && ph_q == 2'd3) begin
                    sh_d = sh_q << 1;
                    if (bit_q == 3'd7) begin
                        state_d = ACKB;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ACKB: begin
                if (tick && ph_q == 2'd2 && !rx && sda_in) ack_d = 1'b1;
                if (tick && ph_q == 2'd3) begin
                    if (ack_q || byte_q == nb_q) begin
                        state_d = STOP;
                    end else begin
                        state_d = BYTE;
                        byte_d  = byte_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick && ph_q == 2'd3) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus pin decode from the current state and quarter.
    always_comb begin
        i2c_sclk = 1'b1;
        sda_low  = 1'b0;
        unique case (state_q)
            START: sda_low = 1'b1;
            BYTE: begin
                i2c_sclk = ph_q[1];
                sda_low  = !rx && !sh_q[DW-1];
            end
            ACKB: begin
                i2c_sclk = ph_q[1];
                sda_low  = rx && (byte_q != nb_q);
            end
            STOP: begin
                i2c_sclk = (ph_q != 2'd0);
                sda_low  = !ph_q[1];
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            nb_q    <= '0;
            sh_q    <= '0;
            ack_q   <= 1'b0;
`ifdef I2C_READ_EN
            rd_mode_q <= 1'b0;
            rd_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            nb_q    <= nb_d;
            sh_q    <= sh_d;
            ack_q   <= ack_d;
`ifdef I2C_READ_EN
            rd_mode_q <= rd_mode_d;
            rd_q      <= rd_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_master_nb.sv
// tb_i2c_master_nb: random frames against a bus-level slave and frame model.
// Define I2C_READ_EN for both files to also exercise read frames.
module tb_i2c_master_nb;

    localparam int DB = 3;
    localparam int QD = 1;
    localparam int DW = 8 * DB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    nbytes = 4'd0;
    logic [DW-1:0] data = '0;
    logic          busy, tr_end, ack, scl;
    wire           sda;
    logic          slave_low = 1'b0;
`ifdef I2C_READ_EN
    logic [DW-1:0] rd_data;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    logic       bits[$];
    logic [7:0] s_rd[8];
    int         s_nack = -1;
    int         s_n = 0;
    bit         s_read = 1'b0;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_nb #(.DATA_BYTES(DB), .QDIV(QD)) dut (
        .clock_i2c (clk),
        .reset_n   (rst_n),
        .start     (start),
        .nbytes    (nbytes),
        .i2c_data  (data),
        .busy      (busy),
        .tr_end    (tr_end),
        .ack       (ack),
        .i2c_sclk  (scl),
`ifdef I2C_READ_EN
        .rd_data   (rd_data),
`endif
        .i2c_sdat  (sda)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave decision for bus bit position p: 1 means pull SDA low.
    function automatic logic slave_drive(input int p);
        int b;
        int i;
        b = p / 9;
        i = p % 9;
        if (b >= s_n) return 1'b0;
        if (i == 8) begin
            if (s_read && b >= 1) return 1'b0;
            return (b != s_nack);
        end
        if (s_read && b >= 1) return !s_rd[b][7-i];
        return 1'b0;
    endfunction

    // Bus monitor and slave: SDA at each SCL rise, START resets the frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            slave_low <= 1'b0;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
        end else begin
            if (scl && scl_p && sda_p && !sda) begin
                bits.delete();
                slave_low <= 1'b0;
            end
            if (scl && !scl_p) bits.push_back(sda);
            if (!scl && scl_p) slave_low <= slave_drive(bits.size());
            scl_p <= scl;
            sda_p <= sda;
        end
    end

    task automatic run_frame(input logic [DW-1:0] d, input int nb,
                             input int nack_b, input int mid_c,
                             input int rst_c);
        int   n_eff, sent, lat, tr_at, tr_cnt, c, nbits;
        logic exp_ack, rd, busy_tr;
        logic [7:0] eb, gb;
        logic [DW-1:0] acc;
        n_eff = (nb == 0) ? 1 : ((nb > DB) ? DB : nb);
        rd = 1'b0;
`ifdef I2C_READ_EN
        rd = d[DW-8];
`endif
        sent = n_eff;
        exp_ack = 1'b0;
        if (nack_b >= 0 && nack_b < n_eff && (!rd || nack_b == 0)) begin
            sent = nack_b + 1;
            exp_ack = 1'b1;
        end
        lat = (6 + 36 * sent) * QD;
        for (int k = 0; k < 8; k++) s_rd[k] = 8'($urandom);
        s_nack = nack_b;
        s_n = n_eff;
        s_read = rd;

        @(negedge clk);
        data = d;
        nbytes = 4'(nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        tr_at = -1;
        tr_cnt = 0;
        busy_tr = 1'b1;
        c = 0;
        while (c < lat + 12 && !(tr_at >= 0 && c > tr_at + 3)) begin
            if (c == mid_c - 1) begin
                start = 1'b1;
                data = DW'({$urandom, $urandom});
            end
            if (c == mid_c) start = 1'b0;
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_scl", scl, 1);
                check("rst_sda_released", sda, 1);
                check("rst_tr_end", tr_end, 0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_idle_busy", busy, 0);
                return;
            end
            @(negedge clk);
            c++;
            if (tr_end) begin
                tr_cnt++;
                if (tr_at < 0) begin
                    tr_at = c;
                    busy_tr = busy;
                end
            end
        end
        check("tr_end_latency", 64'(tr_at), 64'(lat));
        check("tr_end_count", 64'(tr_cnt), 1);
        check("busy_at_tr_end", busy_tr, 0);
        check("ack_flag", ack, exp_ack);
        check("idle_scl", scl, 1);
        check("idle_sda", sda, 1);
        nbits = bits.size();
        check("bit_count", 64'(nbits), 64'(9 * sent + 1));
        if (nbits == 9 * sent + 1) begin
            acc = '0;
            for (int k = 0; k < sent; k++) begin
                eb = (rd && k >= 1) ? s_rd[k] : d[DW-1-8*k -: 8];
                for (int i = 0; i < 8; i++) gb[7-i] = bits[9*k+i];
                check("byte_bits", gb, eb);
                if (rd && k >= 1) begin
                    check("master_ack", bits[9*k+8], (k == n_eff - 1));
                    acc = (acc << 8) | DW'(s_rd[k]);
                end else begin
                    check("slave_ack", bits[9*k+8], (k == nack_b));
                end
            end
            check("stop_bit", bits[9*sent], 0);
`ifdef I2C_READ_EN
            if (rd) check("rd_data", rd_data, acc);
`endif
        end
    endtask

    initial begin
        logic [63:0] r;
        int x;
        #1;
        check("reset_busy", busy, 0);
        check("reset_tr_end", tr_end, 0);
        check("reset_ack", ack, 0);
        check("reset_scl", scl, 1);
        check("reset_sda", sda, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(24'h341E00, 3, -1, -1, -1);
        run_frame(24'h341E00, 3, 0, -1, -1);
        run_frame(24'h341E00, 0, -1, -1, -1);
        run_frame(24'h56A3C8, 9, -1, -1, -1);
        run_frame(24'h341E00, 3, -1, 50, -1);
        run_frame(24'h341E00, 3, -1, -1, 60);
        run_frame(24'h341E00, 3, -1, -1, -1);
        run_frame(24'h341E00, 3, 2, -1, -1);
`ifdef I2C_READ_EN
        run_frame(24'h350000, 2, -1, -1, -1);
`endif
        for (int t = 0; t < 40; t++) begin
            r = {$urandom, $urandom};
            x = int'($urandom_range(0, 5));
            run_frame(r[DW-1:0], int'($urandom_range(0, 15)),
                      (x < DB) ? x : -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
